fft_peak: RTL
=============

FFT_PEAK -- requirements
Module: fft_peak

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, signed width of each real/imag component.
REQ-002 SHALL have parameter N, default 9, log2 of FFT length; the address width is N.
REQ-003 SHALL have parameter MIN_BIN, default 1, the lowest bin eligible for the peak (excludes DC).
REQ-004 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: fft_done  in  1  completion flag from the FFT core; a rising edge starts a sweep.
REQ-007 Port: dout  in  2*BIT_WIDTH  FFT RAM read data {real, imag}, valid 1 cycle after add_rd.
REQ-008 Port: add_rd  out  N  FFT result read address.
REQ-009 Port: busy  out  1  high while the sweep or pipeline drain is in progress.
REQ-010 Port: peak_valid  out  1  one-cycle pulse when a new result is available.
REQ-011 Port: peak_bin  out  N-1  index of the largest-magnitude bin.
REQ-012 Port: peak_mag  out  BIT_WIDTH+1  unsigned magnitude estimate of peak_bin.

Function
REQ-013 FSM states SHALL be IDLE, SWEEP, DRAIN, DONE.
- IDLE->SWEEP on fft_done rising edge (registered previous value, 0 after reset).
- SWEEP->DRAIN after address 2^(N-1)-1 is issued.
- DRAIN->DONE after 2 cycles.
- DONE->IDLE after 1 cycle.
REQ-014 In SWEEP, add_rd SHALL step 0,1,...,2^(N-1)-1, one per cycle; only the lower half of the spectrum is scanned. In IDLE, add_rd SHALL be 0.
REQ-015 Pipeline SHALL be:
- cycle k: address issued;
- k+1: dout sampled with its bin tag;
- k+2: magnitude registered, then compared.
REQ-016 Magnitude SHALL be max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned BIT_WIDTH+1 bits.
- |-2^(BW-1)| = 2^(BW-1), no saturation.
- Maximum result is 49152 for BW=16.
REQ-017 Running peak SHALL clear to bin 0, magnitude 0 when entering SWEEP.
- A bin replaces the peak only if bin >= MIN_BIN and mag is strictly greater.
- Ties therefore keep the lowest bin.
REQ-018 If no eligible bin exceeds 0, the result SHALL be bin MIN_BIN with magnitude 0.
REQ-019 peak_bin and peak_mag SHALL update only in DONE, when peak_valid pulses high for exactly one cycle. Both SHALL hold until the next DONE.
REQ-020 busy SHALL be high in SWEEP and DRAIN and low in IDLE and DONE.
REQ-021 Latency from the fft_done rising-edge cycle to peak_valid SHALL be 2^(N-1)+3 cycles (259 for N=9).
REQ-022 A fft_done edge while busy or in DONE SHALL be ignored, not queued.
REQ-023 dout SHALL be ignored outside the 2-cycle-delayed window of SWEEP addresses.

Reset
REQ-024 While reset=0 on a clock edge, the block SHALL:
- enter IDLE;
- drive add_rd=0, busy=0, peak_valid=0, peak_bin=0, peak_mag=0;
- clear the running peak and the fft_done edge register.
REQ-025 Reset mid-sweep SHALL abort the sweep with no peak_valid pulse. A new sweep requires a fresh fft_done rising edge after reset release.

Structure
REQ-026 The shared package fft_pkg SHALL hold BIT_WIDTH, N, MIN_BIN defaults and the FSM state enum.
REQ-027 The combinational magnitude estimator SHALL be a sub-module mag_est (inputs re, im; output mag). The pipeline register sits after it in fft_peak.
REQ-028 Expected size is 150-250 lines of RTL.

Verification
REQ-029 Single tone: bin 37 = {1000, 0}, all else 0 -> peak_bin=37, peak_mag=1000, peak_valid exactly 259 cycles after the fft_done edge.
REQ-030 Complex: bin 100 = {-300, 400}, bin 5 = {500, 0} -> peak_bin=100, peak_mag=550 (400+150), since 550 > 500.
REQ-031 Tie and DC exclusion: bin 0 = {20000, 0}, bins 10 and 20 = {0, -800} -> peak_bin=10, peak_mag=800.
REQ-032 Extremes: bin 255 = {-32768, -32768} -> peak_bin=255, peak_mag=49152.
REQ-033 Reset and retrigger:
- reset=0 at sweep cycle 100 -> busy=0 next cycle, no peak_valid, outputs 0.
- A later fft_done edge -> correct full result.
REQ-034 A second fft_done edge during busy -> exactly one peak_valid; all-zero spectrum -> peak_bin=1, peak_mag=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak finder.
// Holds the default widths, the lowest eligible bin and the sweep FSM
// state encoding. Both fft_peak and mag_est import this package.
package fft_pkg;

  localparam int FFT_BIT_WIDTH = 16;  // signed width of each re/im component
  localparam int FFT_N         = 9;   // log2 of the FFT length
  localparam int FFT_MIN_BIN   = 1;   // lowest bin allowed to win (skips DC)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_t;

endpackage

// File: rtl/mag_est.sv
// Combinational magnitude estimator: max(|re|,|im|) + min(|re|,|im|)/2.
// Ports:
//   re, im : signed BIT_WIDTH-bit components
//   mag    : unsigned BIT_WIDTH+1-bit estimate (no saturation)
module mag_est
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH
) (
  input  logic signed [BIT_WIDTH-1:0] re,
  input  logic signed [BIT_WIDTH-1:0] im,
  output logic        [BIT_WIDTH:0]   mag
);

  logic [BIT_WIDTH-1:0] w_abs_re;
  logic [BIT_WIDTH-1:0] w_abs_im;
  logic [BIT_WIDTH-1:0] w_max;
  logic [BIT_WIDTH-1:0] w_min;

  always_comb begin
    // Two's-complement negate held as unsigned: the most negative value
    // maps onto 2^(BIT_WIDTH-1), which still fits in BIT_WIDTH bits.
    w_abs_re = re[BIT_WIDTH-1] ? (~re + 1'b1) : re;
    w_abs_im = im[BIT_WIDTH-1] ? (~im + 1'b1) : im;
    if (w_abs_re >= w_abs_im) begin
      w_max = w_abs_re;
      w_min = w_abs_im;
    end else begin
      w_max = w_abs_im;
      w_min = w_abs_re;
    end
    mag = {1'b0, w_max} + {2'b0, w_min[BIT_WIDTH-1:1]};
  end

endmodule

// File: rtl/fft_peak.sv
// FFT peak finder: after each fft_done rising edge, reads the lower half
// of the FFT result RAM, estimates each bin's magnitude and reports the
// largest one (lowest bin wins ties; bins below MIN_BIN never win).
// Ports:
//   clk, reset (sync, active-low)
//   fft_done     : completion flag; a rising edge while IDLE starts a sweep
//   dout         : RAM read data {re, im}, valid one cycle after add_rd
//   add_rd       : RAM read address
//   busy         : high in SWEEP and DRAIN
//   peak_valid   : one-cycle pulse in DONE
//   peak_bin     : winning bin index, held between results
//   peak_mag     : winning magnitude, held between results
//   o_dbg_state  : current FSM state
//
// Handshake: there is no back-pressure. A result is offered for exactly the
// one cycle peak_valid is high; peak_bin/peak_mag stay stable until the next
// peak_valid, so a consumer may also sample them at any later time.
module fft_peak
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = FFT_BIT_WIDTH,
  parameter int N         = FFT_N,
  parameter int MIN_BIN   = FFT_MIN_BIN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic [2*BIT_WIDTH-1:0] dout,
  output logic [N-1:0]           add_rd,
  output logic                   busy,
  output logic                   peak_valid,
  output logic [N-2:0]           peak_bin,
  output logic [BIT_WIDTH:0]     peak_mag,
  output fft_state_t             o_dbg_state
);

  localparam int BIN_W = N - 1;
  localparam logic [BIN_W-1:0] LAST_ADDR = '1;
  localparam logic [BIN_W-1:0] MIN_BIN_V = BIN_W'(MIN_BIN);

  fft_state_t r_state;
  fft_state_t w_next;

  logic                 r_fd_prev;
  logic                 w_fd_rise;
  logic [BIN_W-1:0]     r_addr;
  logic                 r_drain_cnt;

  // Stage 1: tag of the address issued last cycle (its data is on dout now).
  logic                 r_v1;
  logic [BIN_W-1:0]     r_tag1;
  // Stage 2: registered magnitude with its tag, compared in the next cycle.
  logic                 r_v2;
  logic [BIN_W-1:0]     r_tag2;
  logic [BIT_WIDTH:0]   r_mag;

  logic [BIN_W-1:0]     r_pk_bin;
  logic [BIT_WIDTH:0]   r_pk_mag;
  logic [BIN_W-1:0]     r_out_bin;
  logic [BIT_WIDTH:0]   r_out_mag;

  logic signed [BIT_WIDTH-1:0] w_re;
  logic signed [BIT_WIDTH-1:0] w_im;
  logic [BIT_WIDTH:0]   w_mag;
  logic                 w_take;
  logic [BIN_W-1:0]     w_cand_bin;
  logic [BIT_WIDTH:0]   w_cand_mag;
  logic [BIN_W-1:0]     w_final_bin;
  logic                 w_enter_sweep;
  logic                 w_load_out;

  assign w_re = dout[2*BIT_WIDTH-1:BIT_WIDTH];
  assign w_im = dout[BIT_WIDTH-1:0];

  mag_est #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_mag_est (
    .re (w_re),
    .im (w_im),
    .mag(w_mag)
  );

  assign w_fd_rise     = fft_done & ~r_fd_prev;
  assign w_enter_sweep = (r_state == IDLE) && w_fd_rise;
  // The last bin's magnitude is being compared in the final DRAIN cycle, so
  // the result registers take the post-compare value directly.
  assign w_load_out    = (r_state == DRAIN) && r_drain_cnt;

  assign w_take      = r_v2 && (r_tag2 >= MIN_BIN_V) && (r_mag > r_pk_mag);
  assign w_cand_bin  = w_take ? r_tag2 : r_pk_bin;
  assign w_cand_mag  = w_take ? r_mag  : r_pk_mag;
  // Nothing beat zero: report the lowest eligible bin rather than DC.
  assign w_final_bin = (w_cand_mag == '0) ? MIN_BIN_V : w_cand_bin;

  assign add_rd      = {1'b0, r_addr};
  assign peak_bin    = r_out_bin;
  assign peak_mag    = r_out_mag;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    peak_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fd_rise) w_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (r_addr == LAST_ADDR) w_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt) w_next = DONE;
      end
      DONE: begin
        peak_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fd_prev   <= 1'b0;
      r_addr      <= '0;
      r_drain_cnt <= 1'b0;
      r_v1        <= 1'b0;
      r_tag1      <= '0;
      r_v2        <= 1'b0;
      r_tag2      <= '0;
      r_mag       <= '0;
      r_pk_bin    <= '0;
      r_pk_mag    <= '0;
      r_out_bin   <= '0;
      r_out_mag   <= '0;
    end else begin
      r_fd_prev <= fft_done;
      // Wraps to zero naturally after the last address.
      r_addr      <= (r_state == SWEEP) ? r_addr + 1'b1 : '0;
      r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
      r_v1        <= (r_state == SWEEP);
      r_tag1      <= r_addr;
      r_v2        <= r_v1;
      r_tag2      <= r_tag1;
      r_mag       <= w_mag;
      if (w_enter_sweep) begin
        r_pk_bin <= '0;
        r_pk_mag <= '0;
      end else begin
        r_pk_bin <= w_cand_bin;
        r_pk_mag <= w_cand_mag;
      end
      if (w_load_out) begin
        r_out_bin <= w_final_bin;
        r_out_mag <= w_cand_mag;
      end
    end
  end

endmodule
